// File: rtl/dram_arbiter_pkg.sv
// Shared types and defaults for the two-port DRAM arbiter: the memory request and
// response records, the arbiter state type, and the default gap and timeout lengths.
package dram_arbiter_pkg;

    localparam int GAP_CYCLES_DEF = 2;
    localparam int TIMEOUT_DEF    = 4096;
    localparam int TIMER_W        = 16;
    localparam int GAP_W          = 4;

    localparam logic OWN_IMEM = 1'b0;
    localparam logic OWN_DMEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage

// File: rtl/dram_arb_timer.sv
// Saturating up-counter with clear and enable; o_tc flags the LIMIT-th counted cycle.
// LIMIT of 0 keeps o_tc low forever.
module dram_arb_timer #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] TC_VAL = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_tc = (LIMIT > 0) && (r_count == TC_VAL);

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single dram port between instruction and data requesters: round-robin
// grant, registered request, idle gap after each completion, and a busy timeout.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        calib_i,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  dram_in,
    input  mem_out_type dram_out,
    output logic        err_o
);

    arb_state_t  r_state;
    logic        r_owner;
    logic        r_last;
    mem_in_type  r_req;
    logic        r_err;

    arb_state_t  w_state;
    logic        w_owner;
    logic        w_last;
    mem_in_type  w_req;
    logic        w_err;
    logic        w_pick_d;
    mem_out_type w_resp;
    logic        w_gap_tc;
    logic        w_to_tc;
    logic        w_in_gap;
    logic        w_in_busy;

    assign w_in_gap  = (r_state == ST_GAP);
    assign w_in_busy = (r_state == ST_BUSY);

    dram_arb_timer #(.WIDTH(GAP_W), .LIMIT(GAP_CYCLES)) u_gap_timer (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (!w_in_gap),
        .i_en  (w_in_gap),
        .o_tc  (w_gap_tc)
    );

    // Held at zero outside BUSY, so every grant starts the timeout from zero.
    dram_arb_timer #(.WIDTH(TIMER_W), .LIMIT(TIMEOUT)) u_to_timer (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (!w_in_busy),
        .i_en  (w_in_busy),
        .o_tc  (w_to_tc)
    );

    always_comb begin
        w_state  = r_state;
        w_owner  = r_owner;
        w_last   = r_last;
        w_req    = r_req;
        w_err    = r_err;
        w_pick_d = 1'b0;
        w_resp   = '0;

        case (r_state)
            ST_IDLE: begin
                if (calib_i && (imem_in.mem_valid || dmem_in.mem_valid)) begin
                    w_pick_d        = dmem_in.mem_valid &&
                                      (!imem_in.mem_valid || (r_last == OWN_IMEM));
                    w_req           = w_pick_d ? dmem_in : imem_in;
                    w_req.mem_valid = 1'b1;
                    w_owner         = w_pick_d;
                    w_last          = w_pick_d;
                    w_state         = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real ready always wins over a timeout landing in the same cycle.
                w_resp.mem_ready = dram_out.mem_ready || w_to_tc;
                w_resp.mem_rdata = dram_out.mem_ready ? dram_out.mem_rdata : 32'h0;
                if (w_resp.mem_ready) begin
                    w_req.mem_valid = 1'b0;
                    w_state         = ST_GAP;
                    if (!dram_out.mem_ready) begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_gap_tc) begin
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IMEM;
            r_last  <= OWN_IMEM;
            r_req   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_owner <= w_owner;
            r_last  <= w_last;
            r_req   <= w_req;
            r_err   <= w_err;
        end
    end

    assign dram_in  = r_req;
    assign imem_out = (r_owner == OWN_IMEM) ? w_resp : '0;
    assign dmem_out = (r_owner == OWN_DMEM) ? w_resp : '0;
    assign err_o    = r_err;

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized bench for dram_arbiter: a transaction-level model predicts grant order,
// grant cycle, latched request, response and error flag for each transaction.
module tb_dram_arbiter;
    import dram_arbiter_pkg::*;

    localparam int G  = 2;
    localparam int TO = 16;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        calib = 1'b0;
    mem_in_type  imem_in;
    mem_in_type  dmem_in;
    mem_in_type  dram_in;
    mem_out_type imem_out;
    mem_out_type dmem_out;
    mem_out_type dram_out;
    logic        err_o;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          idle_from = 0;
    bit          p_i, p_d, m_last, m_err, own;
    mem_in_type  f_i, f_d, exp_req;
    logic [31:0] g_addr;

    dram_arbiter #(.GAP_CYCLES(G), .TIMEOUT(TO)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .calib_i  (calib),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .dram_in  (dram_in),
        .dram_out (dram_out),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic mem_in_type mk(input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [3:0] wstrb, input logic instr);
        mem_in_type r;
        r.mem_valid = 1'b1;
        r.mem_instr = instr;
        r.mem_addr  = addr;
        r.mem_wdata = wdata;
        r.mem_wstrb = wstrb;
        return r;
    endfunction

    function automatic mem_in_type rnd_req(input logic instr);
        return mk($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), instr);
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        imem_in  = '0;
        dmem_in  = '0;
        dram_out = '0;
        p_i      = 1'b0;
        p_d      = 1'b0;
        tick();
        rst       = 1'b0;
        m_last    = 1'b0;
        m_err     = 1'b0;
        idle_from = cyc;
        #1;
        chk("rst_dram_in", 80'(dram_in), 80'(0));
        chk("rst_imem_out", 80'(imem_out), 80'(0));
        chk("rst_dmem_out", 80'(dmem_out), 80'(0));
        chk("rst_err", 80'(err_o), 80'(0));
    endtask

    task automatic wait_grant(input int exp_v);
        int n;
        n = 0;
        while (1) begin
            tick();
            #1;
            if (dram_in.mem_valid) break;
            chk("wait_imem_out", 80'(imem_out), 80'(0));
            chk("wait_dmem_out", 80'(dmem_out), 80'(0));
            n++;
            if (n > 100) begin
                $display("FAIL grant_wait: no dram_in.mem_valid within 100 cycles, expected at cycle %0d", exp_v);
                $fatal(1, "grant never issued");
            end
        end
        chk("grant_cycle", 80'(cyc), 80'(exp_v));
    endtask

    task automatic serve(input int lat, input logic [31:0] rdv, input bit mut);
        int          tk;
        int          r;
        bit          tout;
        mem_out_type o_own;
        mem_out_type o_oth;
        tout = (lat > TO - 1);
        tk   = tout ? TO - 1 : lat;
        for (int k = 0; k <= tk; k++) begin
            if (k > 0) tick();
            dram_out.mem_ready = (k == lat);
            dram_out.mem_rdata = (k == lat) ? rdv : $urandom;
            if (mut && k == 0) begin
                if (own) begin
                    dmem_in.mem_addr  = ~dmem_in.mem_addr;
                    dmem_in.mem_wdata = ~dmem_in.mem_wdata;
                    dmem_in.mem_wstrb = ~dmem_in.mem_wstrb;
                end else begin
                    imem_in.mem_addr  = ~imem_in.mem_addr;
                    imem_in.mem_wdata = ~imem_in.mem_wdata;
                end
            end
            #1;
            o_own = own ? dmem_out : imem_out;
            o_oth = own ? imem_out : dmem_out;
            chk("busy_req", 80'(dram_in), 80'(exp_req));
            chk("own_ready", 80'(o_own.mem_ready), 80'(k == tk));
            if (k == tk) chk("own_rdata", 80'(o_own.mem_rdata), 80'(tout ? 32'h0 : rdv));
            chk("other_out", 80'(o_oth), 80'(0));
        end
        r = cyc;
        if (tout) m_err = 1'b1;
        tick();
        dram_out = '0;
        if (own) begin
            dmem_in.mem_valid = 1'b0;
            p_d = 1'b0;
        end else begin
            imem_in.mem_valid = 1'b0;
            p_i = 1'b0;
        end
        #1;
        chk("valid_drop", 80'(dram_in.mem_valid), 80'(0));
        chk("err_flag", 80'(err_o), 80'(m_err));
        idle_from = r + G + 1;
    endtask

    task automatic grant_and_serve(input int n, input int lat, input logic [31:0] rdv, input bit mut);
        own     = (p_i && p_d) ? !m_last : p_d;
        m_last  = own;
        exp_req = own ? f_d : f_i;
        wait_grant(imax(n, idle_from) + 1);
        g_addr = dram_in.mem_addr;
        serve(lat, rdv, mut);
    endtask

    task automatic go(input bit ni, input bit nd, input mem_in_type ri, input mem_in_type rq,
                      input int lat, input logic [31:0] rdv, input bit mut);
        int n;
        n = cyc;
        if (ni && !p_i) begin
            p_i = 1'b1;
            f_i = ri;
            f_i.mem_valid = 1'b1;
            imem_in = f_i;
        end
        if (nd && !p_d) begin
            p_d = 1'b1;
            f_d = rq;
            f_d.mem_valid = 1'b1;
            dmem_in = f_d;
        end
        if (p_i || p_d) grant_and_serve(n, lat, rdv, mut);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        mem_in_type none;
        none     = '0;
        imem_in  = '0;
        dmem_in  = '0;
        dram_out = '0;
        do_reset();

        // calibration gating
        calib = 1'b0;
        f_d = mk(32'h100, 32'h0, 4'h0, 1'b0);
        p_d = 1'b1;
        dmem_in = f_d;
        bad = 0;
        repeat (50) begin
            tick();
            #1;
            if (dram_in.mem_valid) bad++;
        end
        chk("calib_block", 80'(bad), 80'(0));
        calib = 1'b1;
        grant_and_serve(cyc, 4, 32'h0BAD_F00D, 1'b0);
        chk("calib_addr", 80'(g_addr), 80'(32'h100));

        // tie-breaking out of reset: dmem first, strict alternation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            go(1'b1, 1'b1, mk(32'h0, 32'h0, 4'h0, 1'b1), mk(32'h40, 32'h0, 4'h0, 1'b0),
               3, 32'h1111_0000 + 32'(i), 1'b0);
            chk("tie_first_dmem", 80'(g_addr), 80'(32'h40));
            go(1'b0, 1'b0, none, none, 2, 32'h2222_0000 + 32'(i), 1'b0);
            chk("tie_then_imem", 80'(g_addr), 80'(32'h0));
        end

        // single read, then an immediate imem request measures the gap
        go(1'b0, 1'b1, none, mk(32'h80, 32'h0, 4'h0, 1'b0), 12, 32'hDEAD_BEEF, 1'b0);
        go(1'b1, 1'b0, mk(32'h200, 32'h0, 4'h0, 1'b1), none, 1, 32'h5555_AAAA, 1'b0);

        // write passthrough, requester changes its fields after grant
        go(1'b0, 1'b1, none, mk(32'h300, 32'h1234_5678, 4'b0011, 1'b0), 6, 32'h0, 1'b1);

        // ready on the last allowed cycle completes normally
        go(1'b1, 1'b0, mk(32'h400, 32'h0, 4'h0, 1'b1), none, TO - 1, 32'hCAFE_F00D, 1'b0);
        chk("last_cycle_no_err", 80'(err_o), 80'(0));

        // timeout, sticky error, next request still served
        go(1'b0, 1'b1, none, mk(32'h500, 32'h0, 4'h0, 1'b0), 40, 32'h7777_7777, 1'b0);
        repeat (5) tick();
        chk("err_sticky", 80'(err_o), 80'(1));
        go(1'b1, 1'b0, mk(32'h600, 32'h0, 4'h0, 1'b1), none, 4, 32'h6060_6060, 1'b0);
        chk("err_still_set", 80'(err_o), 80'(1));

        // reset in the middle of BUSY
        f_d = rnd_req(1'b0);
        p_d = 1'b1;
        dmem_in = f_d;
        m_last = 1'b1;
        wait_grant(imax(cyc, idle_from) + 1);
        tick();
        tick();
        rst = 1'b1;
        dmem_in = '0;
        p_d = 1'b0;
        tick();
        rst = 1'b0;
        dram_out.mem_ready = 1'b1;
        dram_out.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rstbusy_dram_in", 80'(dram_in), 80'(0));
        chk("rstbusy_imem_out", 80'(imem_out), 80'(0));
        chk("rstbusy_dmem_out", 80'(dmem_out), 80'(0));
        chk("rstbusy_err", 80'(err_o), 80'(0));
        dram_out = '0;

        // randomized traffic
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if (!p_i && !p_d) begin
                repeat ($urandom_range(0, 3)) tick();
            end
            go(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_req(1'b1), rnd_req(1'b0),
               int'($urandom_range(0, 19)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
